issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of the per-register in-flight writer counter; saturation value is 2^CNT_W-1.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port flush  input  1  pipeline flush; all in-flight writers are discarded.
REQ-005 SHALL have port stall  input  1  downstream (register-read stage) cannot accept this cycle.
REQ-006 SHALL have ports in0_valid/in1_valid  input  1 each  decoded uop present on lane 0 and lane 1; lane 0 is older.
REQ-007 SHALL have ports inN_rj, inN_rk, inN_rd  input  5 each  source and destination register indices per lane.
REQ-008 SHALL have ports inN_rj_used, inN_rk_used, inN_rd_we  input  1 each  source-read and destination-write qualifiers per lane.
REQ-009 SHALL have ports wb_en_0, wb_en_1  input  1 each, and wb_addr_0, wb_addr_1  input  5 each  register-file write ports from the exe2 stage.
REQ-010 SHALL have ports issue0, issue1  output  1 each  combinational grants; a lane's uop is consumed this cycle.
REQ-011 SHALL have ports eu0_en_out, eu1_en_out  output  1 each  registered copies of issue0/issue1, driving the register-read stage.
REQ-012 SHALL have port busy_vec  output  32  bit r = (cnt[r] != 0).
REQ-013 SHALL have port stall_cnt  output  32  cycles where in0_valid=1 and issue0=0.
REQ-014 SHALL have port wb_err  output  1  sticky; a write-back hit a register whose counter was 0.

Function
REQ-015 SHALL keep one CNT_W-bit counter cnt[r] for r=1..31; register 0 SHALL never be busy and SHALL never be counted.
REQ-016 SHALL define hit(r) = (wb_en_0 & wb_addr_0==r) | (wb_en_1 & wb_addr_1==r); both ports hitting one r SHALL count as a single decrement.
REQ-017 SHALL treat source r as ready if r==0, or cnt[r]==0, or (cnt[r]==1 & hit(r)), since the register file forwards same-cycle write data.
REQ-018 SHALL assert issue0 = in0_valid & !stall & !flush & used sources ready & !(in0_rd_we & in0_rd!=0 & cnt[in0_rd]==max).
REQ-019 SHALL assert issue1 only if issue0, in1_valid, lane-1 used sources are ready, and no lane-1 used source equals in0_rd while in0_rd_we=1 and in0_rd!=0.
REQ-020 SHALL, for issue1 when in1_rd equals in0_rd and both write, require cnt+2 <= max; otherwise it requires cnt < max.
REQ-021 SHALL update each counter next cycle as cnt + inc0 + inc1 - dec, where inc = issued lane writing r, and dec = hit(r) & cnt[r]!=0.
REQ-022 SHALL ignore a hit on cnt[r]==0 without decrementing, and set wb_err.
REQ-023 SHALL, on flush, zero all counters next cycle, overriding same-cycle issue and write-back; issue0 = issue1 = 0 in that cycle.
REQ-024 SHALL register eu0_en_out <= issue0 and eu1_en_out <= issue1, giving one-cycle latency.
REQ-025 SHALL increment stall_cnt by 1 with 32-bit wrap-around; flush does not clear it.
REQ-026 SHALL make issue0/issue1 depend only on current inputs and state, with no combinational path from eu*_en_out.

Reset
REQ-027 SHALL, on rst, set all cnt to 0, eu0_en_out = 0, eu1_en_out = 0, stall_cnt = 0, wb_err = 0; rst has priority over flush.
REQ-028 SHALL hold issue0 = issue1 = 0 during the rst cycle, and discard any write-back during it.

Structure
REQ-029 SHALL take register count (32), index width (5) and CNT_W default from the shared uop package alongside the existing uop definitions.
REQ-030 SHALL contain one sub-module, sb_counter: a single saturating up-by-0/1/2, down-by-0/1 counter instantiated 31 times.

Verification
REQ-031 SHALL cover: issue lane0 rd=5; next cycle lane0 rj=5 used -> issue0=0, stall_cnt increments; wb_en_0=1, wb_addr_0=5 -> issue0=1 in that same cycle.
REQ-032 SHALL cover: lane0 rd=7 we=1 and lane1 rj=7 in one cycle -> issue0=1, issue1=0; lane1 issues next cycle only after write-back of 7.
REQ-033 SHALL cover: CNT_W=2, three issues to rd=3 with no write-back -> cnt[3]=3; fourth writer blocked; one write-back of 3 -> fourth issues.
REQ-034 SHALL cover: busy r1, r2 plus same-cycle issue and flush -> busy_vec=0 next cycle, issue0=0 during the flush.
REQ-035 SHALL cover: write-back to r9 with cnt[9]=0 -> wb_err=1 and stays set; rst -> wb_err=0 and stall_cnt=0.
REQ-036 SHALL cover: rd=0 with we=1 issued repeatedly -> busy_vec stays 0 and issue is never blocked.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared uop definitions and scoreboard sizing
// Provides register-file geometry, the default in-flight counter width,
// the decoded-uop record and the write-back hit helper.
package issue_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int CNT_W_DEF = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rj;
    reg_idx_t rk;
    reg_idx_t rd;
    logic     rj_used;
    logic     rk_used;
    logic     rd_we;
  } uop_t;

  // Both write ports naming the same register still retire one writer.
  function automatic logic wb_hit(input logic en0, input reg_idx_t addr0,
                                  input logic en1, input reg_idx_t addr1,
                                  input reg_idx_t r);
    return (en0 && (addr0 == r)) || (en1 && (addr1 == r));
  endfunction

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// rtl/issue_scoreboard_sb_counter.sv - saturating in-flight writer counter
// Ports: clk, rst (sync, active-high), clr (flush, zeroes next cycle),
//        inc (0..2 new writers), dec (one writer retired), cnt (current value).
module sb_counter
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W+1:0] SAT = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W+1:0] up;
  logic [CNT_W+1:0] nxt;

  // Two guard bits let cnt+2 be formed without wrapping before clamping.
  always_comb begin
    up  = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
    nxt = up;
    if (dec && (up != '0)) begin
      nxt = up - (CNT_W+2)'(1);
    end
    if (nxt > SAT) begin
      nxt = SAT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= nxt[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - dual-lane in-order issue scoreboard
// Ports: clk, rst (sync, active-high), flush, stall;
//        in0_*/in1_* decoded uops (lane 0 older); wb_en_*/wb_addr_* exe2 write-backs;
//        issue0/issue1 combinational grants; eu0_en_out/eu1_en_out registered grants;
//        busy_vec per-register busy; stall_cnt lane-0 stall cycles; wb_err sticky.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 in0_valid,
  input  logic [REG_IDX_W-1:0] in0_rj,
  input  logic [REG_IDX_W-1:0] in0_rk,
  input  logic [REG_IDX_W-1:0] in0_rd,
  input  logic                 in0_rj_used,
  input  logic                 in0_rk_used,
  input  logic                 in0_rd_we,
  input  logic                 in1_valid,
  input  logic [REG_IDX_W-1:0] in1_rj,
  input  logic [REG_IDX_W-1:0] in1_rk,
  input  logic [REG_IDX_W-1:0] in1_rd,
  input  logic                 in1_rj_used,
  input  logic                 in1_rk_used,
  input  logic                 in1_rd_we,
  input  logic                 wb_en_0,
  input  logic [REG_IDX_W-1:0] wb_addr_0,
  input  logic                 wb_en_1,
  input  logic [REG_IDX_W-1:0] wb_addr_1,
  output logic                 issue0,
  output logic                 issue1,
  output logic                 eu0_en_out,
  output logic                 eu1_en_out,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [31:0]          stall_cnt,
  output logic                 wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  uop_t u0;
  uop_t u1;

  always_comb begin
    u0         = '0;
    u0.valid   = in0_valid;
    u0.rj      = in0_rj;
    u0.rk      = in0_rk;
    u0.rd      = in0_rd;
    u0.rj_used = in0_rj_used;
    u0.rk_used = in0_rk_used;
    u0.rd_we   = in0_rd_we;
    u1         = '0;
    u1.valid   = in1_valid;
    u1.rj      = in1_rj;
    u1.rk      = in1_rk;
    u1.rd      = in1_rd;
    u1.rj_used = in1_rj_used;
    u1.rk_used = in1_rk_used;
    u1.rd_we   = in1_rd_we;
  end

  // Register 0 has no counter; its slot reads as permanently idle.
  logic [CNT_W-1:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:1]       hit;
  logic [NUM_REGS-1:0]       busy;
  logic [NUM_REGS-1:0]       rdy;
  logic [NUM_REGS-1:1][1:0]  inc;
  logic [NUM_REGS-1:1]       dec;
  logic [NUM_REGS-1:1]       wb_zero_hit;

  assign cnt[0] = '0;

  // A source whose last in-flight writer retires this cycle is ready now:
  // the register file forwards the same-cycle write data.
  always_comb begin
    hit  = '0;
    busy = '0;
    rdy  = '0;
    rdy[0] = 1'b1;
    for (int r = 1; r < NUM_REGS; r++) begin
      hit[r]  = wb_hit(wb_en_0, wb_addr_0, wb_en_1, wb_addr_1, reg_idx_t'(r));
      busy[r] = (cnt[r] != '0);
      rdy[r]  = !busy[r] || ((cnt[r] == CNT_ONE) && hit[r]);
    end
  end

  logic src0_ok;
  logic dst0_ok;
  logic w0_real;
  logic src1_ok;
  logic raw1;
  logic dst1_ok;

  assign w0_real = u0.rd_we && (u0.rd != '0);
  assign src0_ok = (!u0.rj_used || rdy[u0.rj]) && (!u0.rk_used || rdy[u0.rk]);
  assign dst0_ok = !(w0_real && (cnt[u0.rd] == CNT_MAX));
  assign issue0  = u0.valid && !stall && !flush && !rst && src0_ok && dst0_ok;

  // Lane 1 may not read what lane 0 writes in the same bundle; the counter
  // for that register is not yet raised, so the check is explicit.
  assign src1_ok = (!u1.rj_used || rdy[u1.rj]) && (!u1.rk_used || rdy[u1.rk]);
  assign raw1    = w0_real && ((u1.rj_used && (u1.rj == u0.rd)) ||
                               (u1.rk_used && (u1.rk == u0.rd)));

  always_comb begin
    dst1_ok = 1'b1;
    if (u1.rd_we && (u1.rd != '0)) begin
      if (w0_real && (u1.rd == u0.rd)) begin
        dst1_ok = (({1'b0, cnt[u1.rd]} + (CNT_W+1)'(2)) <= {1'b0, CNT_MAX});
      end else begin
        dst1_ok = (cnt[u1.rd] != CNT_MAX);
      end
    end
  end

  assign issue1 = issue0 && u1.valid && src1_ok && !raw1 && dst1_ok;

  // A write-back to an idle register is a protocol error, not a decrement.
  always_comb begin
    inc         = '0;
    dec         = '0;
    wb_zero_hit = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = {1'b0, issue0 && u0.rd_we && (u0.rd == reg_idx_t'(r))} +
               {1'b0, issue1 && u1.rd_we && (u1.rd == reg_idx_t'(r))};
      dec[r]         = hit[r] && busy[r];
      wb_zero_hit[r] = hit[r] && !busy[r];
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (inc[g]),
      .dec (dec[g]),
      .cnt (cnt[g])
    );
  end

  assign busy_vec = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      eu0_en_out <= 1'b0;
      eu1_en_out <= 1'b0;
      stall_cnt  <= '0;
      wb_err     <= 1'b0;
    end else begin
      eu0_en_out <= issue0;
      eu1_en_out <= issue1;
      if (in0_valid && !issue0) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (|wb_zero_hit) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - scoreboard bench for issue_scoreboard
module tb_issue_scoreboard;

  localparam int MAXC = 3;

  logic        clk, rst, flush, stall;
  logic        in0_valid, in0_rj_used, in0_rk_used, in0_rd_we;
  logic        in1_valid, in1_rj_used, in1_rk_used, in1_rd_we;
  logic [4:0]  in0_rj, in0_rk, in0_rd, in1_rj, in1_rk, in1_rd;
  logic        wb_en_0, wb_en_1;
  logic [4:0]  wb_addr_0, wb_addr_1;
  logic        issue0, issue1, eu0_en_out, eu1_en_out, wb_err;
  logic [31:0] busy_vec, stall_cnt;

  issue_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in0_valid(in0_valid), .in0_rj(in0_rj), .in0_rk(in0_rk), .in0_rd(in0_rd),
    .in0_rj_used(in0_rj_used), .in0_rk_used(in0_rk_used), .in0_rd_we(in0_rd_we),
    .in1_valid(in1_valid), .in1_rj(in1_rj), .in1_rk(in1_rk), .in1_rd(in1_rd),
    .in1_rj_used(in1_rj_used), .in1_rk_used(in1_rk_used), .in1_rd_we(in1_rd_we),
    .wb_en_0(wb_en_0), .wb_addr_0(wb_addr_0), .wb_en_1(wb_en_1), .wb_addr_1(wb_addr_1),
    .issue0(issue0), .issue1(issue1), .eu0_en_out(eu0_en_out), .eu1_en_out(eu1_en_out),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst, flush, stall, v0, v1, uj0, uk0, we0, uj1, uk1, we1, wbe0, wbe1;
    bit [4:0] rj0, rk0, rd0, rj1, rk1, rd1, wba0, wba1;
  } stim_t;

  typedef struct {
    bit chk, i0, i1, eu0, eu1, err;
    bit [31:0] busy, scnt;
  } exp_t;

  exp_t      exp_q[$];
  int        n_cmp = 0;
  int        n_bad = 0;

  // Reference state: number of outstanding writers per architectural register.
  int        cnt_m[32];
  bit        eu0_m, eu1_m, err_m, known;
  bit [31:0] scnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit hit_m(input stim_t s, input int r);
    return (r != 0) && ((s.wbe0 && s.wba0 == r) || (s.wbe1 && s.wba1 == r));
  endfunction

  function automatic bit rdy_m(input stim_t s, input int r);
    return (r == 0) || (cnt_m[r] == 0) || (cnt_m[r] == 1 && hit_m(s, r));
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; flush = s.flush; stall = s.stall;
    in0_valid = s.v0; in0_rj = s.rj0; in0_rk = s.rk0; in0_rd = s.rd0;
    in0_rj_used = s.uj0; in0_rk_used = s.uk0; in0_rd_we = s.we0;
    in1_valid = s.v1; in1_rj = s.rj1; in1_rk = s.rk1; in1_rd = s.rd1;
    in1_rj_used = s.uj1; in1_rk_used = s.uk1; in1_rd_we = s.we1;
    wb_en_0 = s.wbe0; wb_addr_0 = s.wba0; wb_en_1 = s.wbe1; wb_addr_1 = s.wba1;
  endtask

  // Drive one cycle, record what the DUT must show, then advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   i0, i1;
    @(posedge clk);
    #1;
    drive(s);
    i0 = s.v0 && !s.stall && !s.flush && !s.rst
         && (!s.uj0 || rdy_m(s, s.rj0)) && (!s.uk0 || rdy_m(s, s.rk0))
         && !(s.we0 && s.rd0 != 0 && cnt_m[s.rd0] == MAXC);
    i1 = i0 && s.v1 && (!s.uj1 || rdy_m(s, s.rj1)) && (!s.uk1 || rdy_m(s, s.rk1))
         && !(s.we0 && s.rd0 != 0 && ((s.uj1 && s.rj1 == s.rd0) || (s.uk1 && s.rk1 == s.rd0)));
    if (i1 && s.we1 && s.rd1 != 0) begin
      if (s.we0 && s.rd1 == s.rd0) i1 = (cnt_m[s.rd1] + 2 <= MAXC);
      else                          i1 = (cnt_m[s.rd1] < MAXC);
    end
    e.chk = known; e.i0 = i0; e.i1 = i1; e.eu0 = eu0_m; e.eu1 = eu1_m;
    e.err = err_m; e.scnt = scnt_m; e.busy = '0;
    for (int r = 1; r < 32; r++) e.busy[r] = (cnt_m[r] != 0);
    exp_q.push_back(e);
    if (s.rst) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      eu0_m = 0; eu1_m = 0; err_m = 0; scnt_m = 0; known = 1;
    end else begin
      for (int r = 1; r < 32; r++) if (hit_m(s, r) && cnt_m[r] == 0) err_m = 1;
      if (s.v0 && !i0) scnt_m = scnt_m + 1;
      eu0_m = i0; eu1_m = i1;
      for (int r = 1; r < 32; r++) begin
        if (s.flush) cnt_m[r] = 0;
        else cnt_m[r] = cnt_m[r] + int'(i0 && s.we0 && s.rd0 == r)
                        + int'(i1 && s.we1 && s.rd1 == r)
                        - int'(hit_m(s, r) && cnt_m[r] != 0);
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue0", issue0, e.i0);
        check("issue1", issue1, e.i1);
        if (e.chk) begin
          check("eu0_en_out", eu0_en_out, e.eu0);
          check("eu1_en_out", eu1_en_out, e.eu1);
          check("busy_vec", busy_vec, e.busy);
          check("stall_cnt", stall_cnt, e.scnt);
          check("wb_err", wb_err, e.err);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    busy_l[$];
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    eu0_m = 0; eu1_m = 0; err_m = 0; scnt_m = 0; known = 0;
    drive(idle());

    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);
    check("reset_busy", busy_vec, 0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_wb_err", wb_err, 0);
    check("reset_eu0", eu0_en_out, 0);

    // RAW on r5 resolved by same-cycle write-back forwarding
    s = idle(); s.v0 = 1; s.rd0 = 5; s.we0 = 1; step(s);
    check("raw5_first_issue", issue0, 1);
    s = idle(); s.v0 = 1; s.rj0 = 5; s.uj0 = 1; step(s);
    check("raw5_blocked", issue0, 0);
    check("raw5_busy", busy_vec, 32'h20);
    s.wbe0 = 1; s.wba0 = 5; step(s);
    check("raw5_forward_issue", issue0, 1);
    check("raw5_stall_cnt", stall_cnt, 1);
    s = idle(); step(s);
    check("raw5_released", busy_vec, 0);

    // intra-bundle RAW on r7
    s = idle(); s.v0 = 1; s.rd0 = 7; s.we0 = 1; s.v1 = 1; s.rj1 = 7; s.uj1 = 1; step(s);
    check("raw7_lane0", issue0, 1);
    check("raw7_lane1_held", issue1, 0);
    s = idle(); s.v0 = 1; s.v1 = 1; s.rj1 = 7; s.uj1 = 1; step(s);
    check("raw7_lane1_wait", issue1, 0);
    s.wbe1 = 1; s.wba1 = 7; step(s);
    check("raw7_lane1_go", issue1, 1);

    // counter saturation on r3
    s = idle(); s.v0 = 1; s.rd0 = 3; s.we0 = 1;
    for (int k = 0; k < 3; k++) begin
      step(s);
      check("sat3_issue", issue0, 1);
    end
    step(s);
    check("sat3_fourth_blocked", issue0, 0);
    s.wbe0 = 1; s.wba0 = 3; step(s);
    check("sat3_wb_cycle_blocked", issue0, 0);
    s.wbe0 = 0; step(s);
    check("sat3_fourth_issues", issue0, 1);

    // flush discards in-flight writers and blocks same-cycle issue
    s = idle(); s.v0 = 1; s.rd0 = 1; s.we0 = 1; s.v1 = 1; s.rd1 = 2; s.we1 = 1; step(s);
    check("flush_setup_lane1", issue1, 1);
    s = idle(); s.v0 = 1; s.rd0 = 4; s.we0 = 1; s.flush = 1; step(s);
    check("flush_issue0", issue0, 0);
    check("flush_busy_before", busy_vec, 32'h0E);
    s = idle(); step(s);
    check("flush_busy_after", busy_vec, 0);

    // stray write-back sets sticky error; reset clears it
    s = idle(); s.wbe0 = 1; s.wba0 = 9; step(s);
    s = idle(); step(s);
    check("wb_err_set", wb_err, 1);
    step(s); step(s);
    check("wb_err_sticky", wb_err, 1);
    s.rst = 1; step(s);
    s = idle(); step(s);
    check("wb_err_cleared", wb_err, 0);
    check("stall_cnt_cleared", stall_cnt, 0);

    // r0 destinations never occupy the scoreboard
    s = idle(); s.v0 = 1; s.we0 = 1; s.v1 = 1; s.we1 = 1;
    for (int k = 0; k < 5; k++) begin
      step(s);
      check("r0_issue0", issue0, 1);
      check("r0_issue1", issue1, 1);
    end
    check("r0_busy", busy_vec, 0);

    // randomized traffic on a small register window to force conflicts
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 299) == 0);
      s.flush = ($urandom_range(0, 39) == 0);
      s.stall = ($urandom_range(0, 9) == 0);
      s.v0 = ($urandom_range(0, 9) < 7); s.v1 = ($urandom_range(0, 9) < 6);
      s.rj0 = 5'($urandom_range(0, 7)); s.rk0 = 5'($urandom_range(0, 7));
      s.rd0 = 5'($urandom_range(0, 7)); s.rj1 = 5'($urandom_range(0, 7));
      s.rk1 = 5'($urandom_range(0, 7)); s.rd1 = 5'($urandom_range(0, 7));
      s.uj0 = 1'($urandom_range(0, 1)); s.uk0 = 1'($urandom_range(0, 1));
      s.uj1 = 1'($urandom_range(0, 1)); s.uk1 = 1'($urandom_range(0, 1));
      s.we0 = ($urandom_range(0, 9) < 7); s.we1 = ($urandom_range(0, 9) < 7);
      busy_l.delete();
      for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) busy_l.push_back(r);
      if (busy_l.size() > 0) begin
        s.wbe0 = ($urandom_range(0, 9) < 5);
        s.wba0 = 5'(busy_l[$urandom_range(0, busy_l.size() - 1)]);
        s.wbe1 = ($urandom_range(0, 9) < 4);
        s.wba1 = 5'(busy_l[$urandom_range(0, busy_l.size() - 1)]);
      end
      if ($urandom_range(0, 99) == 0) begin
        s.wbe1 = 1; s.wba1 = 5'($urandom_range(1, 7));
      end
      step(s);
    end

    s = idle(); step(s); step(s);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
